l2_cache_control: RTL and testbench
===================================

// Module: l2_cache_control
// PURPOSE
//  Control FSM for the 2-way, 16-set, 256-bit-line L2 cache. Per way, the datapath holds one
//  l2_array instance each for data, tag, valid and dirty, plus a 16-entry LRU array.
//  Sits between the L1 miss port (mem_*) and physical memory (pmem_*).
//  Sequences hit, write-back and fill; drives the array load enables and datapath muxes.
//  Keeps saturating hit/miss performance counters.
// PARAMETERS
//  CNT_W   16   width of hit_count / miss_count (saturating)
// PORTS
//  clk          in   1      system clock; all state updates on posedge
//  rst          in   1      synchronous, active-high reset
//  mem_read     in   1      L1 line read request; held until mem_resp
//  mem_write    in   1      L1 line write request; held until mem_resp
//  mem_resp     out  1      one-cycle completion pulse to L1
//  hit          in   2      per-way tag match AND valid, from datapath (combinational)
//  dirty        in   2      per-way dirty bit at current index
//  lru          in   1      LRU way at current index (0/1)
//  pmem_read    out  1      line fill request; held until pmem_resp
//  pmem_write   out  1      victim write-back request; held until pmem_resp
//  pmem_resp    in   1      one-cycle completion from physical memory
//  way_ld       out  2      per-way load of data+tag+valid arrays
//  dirty_ld     out  2      per-way load of dirty array
//  dirty_in     out  1      value written to dirty array
//  lru_ld       out  1      load LRU array
//  lru_in       out  1      value written to LRU array (way NOT just used)
//  data_sel     out  1      0: L1 write line into data array; 1: pmem line
//  paddr_sel    out  1      0: miss address {tag,index,5'b0}; 1: victim {victim_tag,index,5'b0}
//  hit_count    out  CNT_W  completed hits (includes post-fill re-check hits)
//  miss_count   out  CNT_W  misses detected in CHECK
// BEHAVIOUR
//  - Reset: state=IDLE, victim=0, counters=0.
//    All outputs 0 on the cycle after the reset edge, including mid write-back/fill.
//    The abandoned pmem transaction is dropped; a late pmem_resp in IDLE is ignored.
//  - Default outputs are 0 in every state unless listed below. Outputs are Moore/Mealy from
//    state+inputs; no output registers.
//  - mem_read & mem_write together: treated as write.
//  - hit==2'b11 (illegal): way 0 wins.
//  - IDLE: mem_read|mem_write -> CHECK. (One cycle lets index/tag settle through the arrays.)
//  - CHECK, hit: mem_resp=1; lru_ld=1, lru_in=~hit_way.
//      On write, also way_ld[hit_way]=1, data_sel=0, dirty_ld[hit_way]=1, dirty_in=1.
//      hit_count++ (saturate at all-ones). -> IDLE.
//  - CHECK, miss: latch victim<=lru; miss_count++ (saturate).
//      -> WB if dirty[lru], else FILL.
//  - WB: pmem_write=1, paddr_sel=1; wait. On pmem_resp -> FILL.
//  - FILL: pmem_read=1, paddr_sel=0.
//      On pmem_resp: way_ld[victim]=1, data_sel=1, dirty_ld[victim]=1, dirty_in=0; -> CHECK.
//      The re-check then hits and completes, so miss latency = 2 + WB + fill + 1 cycles.
//  - Hit latency: request seen in IDLE at cycle t -> mem_resp at t+1.
//  - mem_resp is never asserted outside CHECK. pmem_read and pmem_write are never both 1.
//  - Requester must hold request and address until mem_resp; dropping it early is unsupported.
// STRUCTURE
//  - l2_types_pkg: state_t enum {IDLE, CHECK, WB, FILL}; way_t (logic [0:0]);
//    localparam NUM_WAYS=2, NUM_SETS=16, LINE_W=256.
//  - Sub-module l2_sat_counter #(CNT_W) (clk, rst, inc, count); instantiated twice.
//  - Victim register and FSM live in l2_cache_control. Datapath is separate (l2_cache_datapath).
// TESTING
//  1. Reset, then read addr 0x0000_0040 (index 2), all invalid, clean -> pmem_read with paddr_sel=0,
//     pmem_resp after 5 cycles -> way_ld=2'b01, then mem_resp; miss_count=1, hit_count=1.
//  2. Repeat read of 0x40 -> mem_resp exactly 1 cycle after IDLE sees request;
//     lru_in=1; no pmem activity.
//  3. Write hit to way 1 at index 2 -> way_ld=2'b10, dirty_ld=2'b10, dirty_in=1, data_sel=0,
//     mem_resp same cycle.
//  4. Conflict miss at index 2 with lru=1, dirty=2'b10 -> pmem_write with paddr_sel=1 until pmem_resp,
//     then pmem_read, way_ld=2'b10, data_sel=1, dirty_in=0, then mem_resp.
//  5. Assert rst during WB -> next cycle all outputs 0, state IDLE.
//     Stray pmem_resp ignored; counters 0.
//  6. Force hit_count to 0xFFFF via 65535 hits (or bench backdoor), one more hit -> stays 0xFFFF.

Source files
------------

// File: rtl/l2_types_pkg.sv
// Shared types and geometry for the 2-way, 16-set, 256-bit-line L2 cache.
// Imported by the controller, its sub-modules and the datapath.
package l2_types_pkg;

  localparam int NUM_WAYS = 2;
  localparam int NUM_SETS = 16;
  localparam int LINE_W   = 256;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WB,
    FILL
  } state_t;

  typedef logic [0:0] way_t;

  // Way 0 wins if both ways report a hit; with no hit the result is unused.
  function automatic way_t pick_hit_way(logic [NUM_WAYS-1:0] h);
    return (h[0] || !h[1]) ? 1'b0 : 1'b1;
  endfunction

endpackage

// File: rtl/l2_cache_control_if.sv
// L1 miss port (mem_*) and physical memory port (pmem_*) seen by the L2 controller.
// The slave modport is the controller; the master modport is its surroundings.
interface l2_cache_control_if;

  logic mem_read;
  logic mem_write;
  logic mem_resp;
  logic pmem_read;
  logic pmem_write;
  logic pmem_resp;

  modport master (
    output mem_read,
    output mem_write,
    output pmem_resp,
    input  mem_resp,
    input  pmem_read,
    input  pmem_write
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  pmem_resp,
    output mem_resp,
    output pmem_read,
    output pmem_write
  );

endinterface

// File: rtl/l2_sat_counter.sv
// Saturating up-counter used for the L2 hit and miss performance counters.
// Once it reaches all-ones it holds there until reset.
module l2_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/l2_cache_control.sv
// Control FSM for the 2-way L2 cache: sequences hit, victim write-back and line fill,
// drives the datapath array load enables and muxes, and keeps hit/miss counters.
module l2_cache_control
  import l2_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  l2_cache_control_if.slave   bus,
  input  logic [NUM_WAYS-1:0] hit,
  input  logic [NUM_WAYS-1:0] dirty,
  input  way_t                lru,
  output logic [NUM_WAYS-1:0] way_ld,
  output logic [NUM_WAYS-1:0] dirty_ld,
  output logic                dirty_in,
  output logic                lru_ld,
  output logic                lru_in,
  output logic                data_sel,
  output logic                paddr_sel,
  output logic [CNT_W-1:0]    hit_count,
  output logic [CNT_W-1:0]    miss_count
);

  state_t state;
  state_t next_state;
  way_t   victim;
  way_t   hit_way;
  logic   any_hit;
  logic   is_write;
  logic   hit_inc;
  logic   miss_inc;
  logic   mem_resp;
  logic   pmem_read;
  logic   pmem_write;

  assign any_hit  = |hit;
  assign hit_way  = pick_hit_way(hit);
  assign is_write = bus.mem_write;

  assign bus.mem_resp   = mem_resp;
  assign bus.pmem_read  = pmem_read;
  assign bus.pmem_write = pmem_write;

  // The victim is captured at miss detection so a later LRU update cannot redirect the fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      victim <= '0;
    end else begin
      state <= next_state;
      if (miss_inc) begin
        victim <= lru;
      end
    end
  end

  always_comb begin
    next_state = state;
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    way_ld     = '0;
    dirty_ld   = '0;
    dirty_in   = 1'b0;
    lru_ld     = 1'b0;
    lru_in     = 1'b0;
    data_sel   = 1'b0;
    paddr_sel  = 1'b0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          next_state = CHECK;
        end
      end

      CHECK: begin
        if (any_hit) begin
          mem_resp   = 1'b1;
          lru_ld     = 1'b1;
          lru_in     = ~hit_way;
          hit_inc    = 1'b1;
          next_state = IDLE;
          if (is_write) begin
            way_ld[hit_way]   = 1'b1;
            dirty_ld[hit_way] = 1'b1;
            dirty_in          = 1'b1;
          end
        end else begin
          miss_inc   = 1'b1;
          next_state = dirty[lru] ? WB : FILL;
        end
      end

      WB: begin
        pmem_write = 1'b1;
        paddr_sel  = 1'b1;
        if (bus.pmem_resp) begin
          next_state = FILL;
        end
      end

      FILL: begin
        pmem_read = 1'b1;
        // Returning to CHECK lets the freshly filled way complete the request as a hit.
        if (bus.pmem_resp) begin
          way_ld[victim]   = 1'b1;
          dirty_ld[victim] = 1'b1;
          data_sel         = 1'b1;
          next_state       = CHECK;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  l2_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_count)
  );

  l2_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_count)
  );

endmodule

// File: tb/tb_l2_cache_control.sv
// Directed bench for l2_cache_control: hit, write hit, clean and dirty misses, reset abort,
// and counter saturation on a narrow-counter instance.
module tb_l2_cache_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  hit;
  logic [1:0]  dirty;
  logic [0:0]  lru;
  logic [1:0]  way_ld;
  logic [1:0]  dirty_ld;
  logic        dirty_in;
  logic        lru_ld;
  logic        lru_in;
  logic        data_sel;
  logic        paddr_sel;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  logic [1:0]  s_hit;
  logic [1:0]  s_dirty;
  logic [0:0]  s_lru;
  logic [1:0]  s_way_ld;
  logic [1:0]  s_dirty_ld;
  logic        s_dirty_in;
  logic        s_lru_ld;
  logic        s_lru_in;
  logic        s_data_sel;
  logic        s_paddr_sel;
  logic [3:0]  s_hit_count;
  logic [3:0]  s_miss_count;

  int checks;
  int errors;

  always #5 clk = ~clk;

  l2_cache_control_if bus_if ();
  l2_cache_control_if sbus_if ();

  l2_cache_control #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if.slave),
    .hit        (hit),
    .dirty      (dirty),
    .lru        (lru),
    .way_ld     (way_ld),
    .dirty_ld   (dirty_ld),
    .dirty_in   (dirty_in),
    .lru_ld     (lru_ld),
    .lru_in     (lru_in),
    .data_sel   (data_sel),
    .paddr_sel  (paddr_sel),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  // Narrow counters make saturation reachable within a short run.
  l2_cache_control #(.CNT_W(4)) dut_small (
    .clk        (clk),
    .rst        (rst),
    .bus        (sbus_if.slave),
    .hit        (s_hit),
    .dirty      (s_dirty),
    .lru        (s_lru),
    .way_ld     (s_way_ld),
    .dirty_ld   (s_dirty_ld),
    .dirty_in   (s_dirty_in),
    .lru_ld     (s_lru_ld),
    .lru_in     (s_lru_in),
    .data_sel   (s_data_sel),
    .paddr_sel  (s_paddr_sel),
    .hit_count  (s_hit_count),
    .miss_count (s_miss_count)
  );

  task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] h,
                               input logic [1:0] d, input logic l, input logic presp);
    bus_if.mem_read  = rd;
    bus_if.mem_write = wr;
    hit              = h;
    dirty            = d;
    lru              = l;
    bus_if.pmem_resp = presp;
    #1;
  endtask

  // Packed order: mem_resp pmem_read pmem_write way_ld dirty_ld dirty_in lru_ld lru_in data_sel paddr_sel
  task automatic checkOutput(input string tag, input logic resp, input logic pr, input logic pw,
                             input logic [1:0] wl, input logic [1:0] dl, input logic di,
                             input logic ll, input logic li, input logic ds, input logic ps);
    logic [11:0] observed;
    logic [11:0] expected;
    observed = {bus_if.mem_resp, bus_if.pmem_read, bus_if.pmem_write, way_ld, dirty_ld,
                dirty_in, lru_ld, lru_in, data_sel, paddr_sel};
    expected = {resp, pr, pw, wl, dl, di, ll, li, ds, ps};
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic checkCount(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    sbus_if.mem_read  = 1'b0;
    sbus_if.mem_write = 1'b0;
    sbus_if.pmem_resp = 1'b0;
    s_hit   = 2'b00;
    s_dirty = 2'b00;
    s_lru   = 1'b0;
    applyStimulus(0, 0, 2'b00, 2'b00, 0, 0);
    repeat (2) @(negedge clk);

    checkOutput("reset_outputs", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    checkCount("reset_hit_count", 32'(hit_count), 0);
    checkCount("reset_miss_count", 32'(miss_count), 0);
    rst = 1'b0;

    // Cold read miss at index 2: clean victim way 0, fill answered on the fifth FILL cycle.
    applyStimulus(1, 0, 2'b00, 2'b00, 0, 0);
    checkOutput("t1_idle", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t1_check_miss", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("t1_fill_wait", 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    end
    @(negedge clk);
    applyStimulus(1, 0, 2'b00, 2'b00, 0, 1);
    checkOutput("t1_fill_done", 0, 1, 0, 2'b01, 2'b01, 0, 0, 0, 1, 0);
    @(negedge clk);
    applyStimulus(1, 0, 2'b01, 2'b00, 0, 0);
    checkOutput("t1_recheck_hit", 1, 0, 0, 2'b00, 2'b00, 0, 1, 1, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 2'b00, 2'b00, 1, 0);
    checkOutput("t1_back_idle", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    checkCount("t1_miss_count", 32'(miss_count), 1);
    checkCount("t1_hit_count", 32'(hit_count), 1);

    // Repeat read: one cycle in IDLE, mem_resp on the next.
    applyStimulus(1, 0, 2'b01, 2'b00, 1, 0);
    checkOutput("t2_idle", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t2_read_hit", 1, 0, 0, 2'b00, 2'b00, 0, 1, 1, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 2'b00, 2'b00, 0, 0);
    checkCount("t2_hit_count", 32'(hit_count), 2);

    // Write hit in way 1.
    applyStimulus(0, 1, 2'b10, 2'b00, 0, 0);
    checkOutput("t3_idle", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t3_write_hit", 1, 0, 0, 2'b10, 2'b10, 1, 1, 0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 2'b00, 2'b00, 1, 0);
    checkCount("t3_hit_count", 32'(hit_count), 3);

    // Conflict miss with dirty LRU way 1; lru flips mid-miss, victim must stay way 1.
    applyStimulus(1, 0, 2'b00, 2'b10, 1, 0);
    @(negedge clk);
    checkOutput("t4_check_miss", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    @(negedge clk);
    applyStimulus(1, 0, 2'b00, 2'b10, 0, 0);
    checkOutput("t4_wb_wait", 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("t4_wb_wait2", 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 1);
    @(negedge clk);
    applyStimulus(1, 0, 2'b00, 2'b10, 0, 1);
    checkOutput("t4_wb_resp", 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 1);
    @(negedge clk);
    applyStimulus(1, 0, 2'b00, 2'b10, 0, 0);
    checkOutput("t4_fill_wait", 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    @(negedge clk);
    applyStimulus(1, 0, 2'b00, 2'b10, 0, 1);
    checkOutput("t4_fill_done", 0, 1, 0, 2'b10, 2'b10, 0, 0, 0, 1, 0);
    @(negedge clk);
    applyStimulus(1, 0, 2'b10, 2'b00, 0, 0);
    checkOutput("t4_recheck_hit", 1, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 2'b00, 2'b00, 0, 0);
    checkCount("t4_miss_count", 32'(miss_count), 2);
    checkCount("t4_hit_count", 32'(hit_count), 4);

    // Read and write together with both ways hitting: a write into way 0.
    applyStimulus(1, 1, 2'b11, 2'b00, 0, 0);
    @(negedge clk);
    checkOutput("t_rw_both_hit", 1, 0, 0, 2'b01, 2'b01, 1, 1, 1, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 2'b00, 2'b00, 0, 0);
    checkCount("t_rw_hit_count", 32'(hit_count), 5);

    // Reset in the middle of a write-back, then a stray pmem_resp.
    applyStimulus(1, 0, 2'b00, 2'b01, 0, 0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t5_in_wb", 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 1);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(1, 0, 2'b00, 2'b01, 0, 1);
    checkOutput("t5_after_reset", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    checkCount("t5_hit_cleared", 32'(hit_count), 0);
    checkCount("t5_miss_cleared", 32'(miss_count), 0);
    rst = 1'b0;
    applyStimulus(0, 0, 2'b00, 2'b00, 0, 1);
    checkOutput("t5_stray_resp", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 2'b00, 2'b00, 0, 0);
    checkOutput("t5_still_idle", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 2'b01, 2'b00, 0, 0);
    @(negedge clk);
    checkOutput("t5_hit_after_reset", 1, 0, 0, 2'b00, 2'b00, 0, 1, 1, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 2'b00, 2'b00, 0, 0);
    checkCount("t5_hit_count", 32'(hit_count), 1);
    checkCount("t5_miss_count", 32'(miss_count), 0);

    // Back-to-back hits on the 4-bit instance: one hit per two cycles.
    sbus_if.mem_read = 1'b1;
    s_hit            = 2'b01;
    repeat (28) @(negedge clk);
    checkCount("t6_count_14", 32'(s_hit_count), 14);
    repeat (2) @(negedge clk);
    checkCount("t6_count_15", 32'(s_hit_count), 15);
    repeat (2) @(negedge clk);
    checkCount("t6_saturated", 32'(s_hit_count), 15);
    repeat (6) @(negedge clk);
    checkCount("t6_still_saturated", 32'(s_hit_count), 15);
    checkCount("t6_no_misses", 32'(s_miss_count), 0);
    sbus_if.mem_read = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
